// File: rtl/ratio_measure.sv
// ratio_measure: measures the Clk-to-Ref_In frequency ratio (x100) by
// counting Clk cycles over K reference periods and dividing by K with
// a 32-step restoring divider.
// Optional feature macro: RATIO_AVG_EN -- when defined, results pass through
// a 4-entry moving-average buffer and DONE takes two cycles.
module ratio_measure #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        En,
    input  logic        Start,
    input  logic        Ref_In,
    input  logic [7:0]  Num_Periods,
    output logic [31:0] Ratio_Crystal,
    output logic        Valid,
    output logic        Busy,
    output logic        Timeout_Err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [7:0]  r_k;
    logic [23:0] r_tmo;
    logic [23:0] r_cnt;
    logic [7:0]  r_edge_cnt;
    logic [31:0] r_dvd;       // dividend shifts out MSB-first, quotient shifts in
    logic [7:0]  r_rem;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_ratio;
    logic        r_valid;
    logic        r_busy;
    logic        r_tmo_err;

    logic        w_edge;
    logic [23:0] w_tmo_next;
    logic        w_tmo_hit;
    logic [7:0]  w_edge_next;
    logic [23:0] w_total;
    logic [31:0] w_product;
    logic [8:0]  w_rem_sh;
    logic        w_ge;
    logic [7:0]  w_rem_sub;

`ifdef RATIO_AVG_EN
    logic [31:0] r_buf [4];
    logic        r_first;
    logic        r_done_ph;
    logic [33:0] w_sum;
    logic [31:0] w_avg;

    assign w_sum = {2'b00, r_buf[0]} + {2'b00, r_buf[1]} + {2'b00, r_buf[2]} + {2'b00, r_buf[3]};
    assign w_avg = 32'(w_sum >> 2);
`endif

    // Rising edge = synchronized level high while the previous sample was low.
    assign w_edge      = r_sync2 & ~r_prev;
    assign w_tmo_next  = r_tmo + 24'd1;
    assign w_tmo_hit   = (w_tmo_next == TIMEOUT_CYCLES);
    assign w_edge_next = r_edge_cnt + 8'd1;
    // Total cycles over K periods; the synchronizer delay is common to both
    // end edges so it cancels.
    assign w_total     = r_cnt + 24'd1;
    assign w_product   = {8'd0, w_total} * 32'd100;
    // One restoring-division step: shift in next dividend bit, trial-subtract K.
    // The remainder stays below K, so an 8-bit difference is exact.
    assign w_rem_sh    = {r_rem, r_dvd[31]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_k});
    assign w_rem_sub   = w_rem_sh[7:0] - r_k;

    assign Ratio_Crystal = r_ratio;
    assign Valid         = r_valid;
    assign Busy          = r_busy;
    assign Timeout_Err   = r_tmo_err;

    // Two-flop synchronizer plus previous-sample flop for edge detection; frozen when En is low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else if (En) begin
            r_sync1 <= Ref_In;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Measurement FSM: arm, count K periods, divide, publish result; all outputs registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_k        <= 8'd0;
            r_tmo      <= 24'd0;
            r_cnt      <= 24'd0;
            r_edge_cnt <= 8'd0;
            r_dvd      <= 32'd0;
            r_rem      <= 8'd0;
            r_div_cnt  <= 5'd0;
            r_ratio    <= 32'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_tmo_err  <= 1'b0;
`ifdef RATIO_AVG_EN
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= 32'd0;
            end
            r_first    <= 1'b1;
            r_done_ph  <= 1'b0;
`endif
        end else if (!En) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Timeout wins over an edge arriving in the same cycle.
            if (((r_state == ST_ARM) || (r_state == ST_COUNT)) && w_tmo_hit) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_tmo_err <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (Start) begin
                            r_k        <= (Num_Periods == 8'd0) ? 8'd1 : Num_Periods;
                            r_tmo      <= 24'd0;
                            r_cnt      <= 24'd0;
                            r_edge_cnt <= 8'd0;
                            r_tmo_err  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        r_tmo <= w_tmo_next;
                        if (w_edge) begin
                            r_cnt      <= 24'd0;
                            r_edge_cnt <= 8'd0;
                            r_state    <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        r_tmo <= w_tmo_next;
                        r_cnt <= r_cnt + 24'd1;
                        if (w_edge) begin
                            r_edge_cnt <= w_edge_next;
                            if (w_edge_next == r_k) begin
                                r_dvd     <= w_product;
                                r_rem     <= 8'd0;
                                r_div_cnt <= 5'd0;
                                r_state   <= ST_DIVIDE;
                            end
                        end
                    end
                    ST_DIVIDE: begin
                        r_rem     <= w_ge ? w_rem_sub : w_rem_sh[7:0];
                        r_dvd     <= {r_dvd[30:0], w_ge};
                        r_div_cnt <= r_div_cnt + 5'd1;
                        if (r_div_cnt == 5'd31) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
`ifdef RATIO_AVG_EN
                        if (!r_done_ph) begin
                            // First result after reset seeds the whole window.
                            if (r_first) begin
                                for (int i = 0; i < 4; i++) begin
                                    r_buf[i] <= r_dvd;
                                end
                                r_first <= 1'b0;
                            end else begin
                                r_buf[0] <= r_dvd;
                                r_buf[1] <= r_buf[0];
                                r_buf[2] <= r_buf[1];
                                r_buf[3] <= r_buf[2];
                            end
                            r_done_ph <= 1'b1;
                        end else begin
                            r_ratio   <= w_avg;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_done_ph <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
`else
                        r_ratio <= r_dvd;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`endif
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ratio_measure.sv
// Directed testbench for ratio_measure (default build, TIMEOUT_CYCLES=100).
module tb_ratio_measure;

    logic        Clk;
    logic        Reset_n;
    logic        En;
    logic        Start;
    logic        Ref_In;
    logic [7:0]  Num_Periods;
    logic [31:0] Ratio_Crystal;
    logic        Valid;
    logic        Busy;
    logic        Timeout_Err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference generator controls: one-cycle high pulse at the start of each
    // period, period alternating between per_a and per_b.
    int per_a     = 4;
    int per_b     = 4;
    bit gen_on    = 1'b0;
    bit gen_pause = 1'b0;
    int gctr      = 0;
    bit gsel      = 1'b0;

    ratio_measure #(.TIMEOUT_CYCLES(24'd100)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .En            (En),
        .Start         (Start),
        .Ref_In        (Ref_In),
        .Num_Periods   (Num_Periods),
        .Ratio_Crystal (Ratio_Crystal),
        .Valid         (Valid),
        .Busy          (Busy),
        .Timeout_Err   (Timeout_Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Ref_In updates 2 time units after each rising edge; pausing freezes it
    // in lock-step with the DUT when En is dropped.
    initial begin
        Ref_In = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            if (!gen_on) begin
                Ref_In = 1'b0;
                gctr   = 0;
                gsel   = 1'b0;
            end else if (!gen_pause) begin
                Ref_In = (gctr == 0);
                gctr++;
                if (gctr >= (gsel ? per_b : per_a)) begin
                    gctr = 0;
                    gsel = ~gsel;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_gen(input int a, input int b, input bit on);
        @(negedge Clk);
        gen_on = 1'b0;
        repeat (3) @(negedge Clk);
        per_a  = a;
        per_b  = b;
        gen_on = on;
        repeat (12) @(negedge Clk);
    endtask

    // Start pulse; Num_Periods is scrambled afterwards since it must be captured on Start.
    task automatic pulse_start(input logic [7:0] k);
        @(negedge Clk);
        Num_Periods = k;
        Start       = 1'b1;
        @(negedge Clk);
        Start       = 1'b0;
        Num_Periods = 8'hFF;
    endtask

    task automatic run_measure(input logic [7:0] k, input int window,
                               output logic [31:0] ratio, output int nvalid);
        pulse_start(k);
        nvalid = 0;
        ratio  = 32'hxxxxxxxx;
        for (int i = 0; i < window; i++) begin
            @(negedge Clk);
            if (Valid) begin
                if (nvalid == 0) ratio = Ratio_Crystal;
                nvalid++;
            end
        end
    endtask

    task automatic test_reset;
        Reset_n     = 1'b0;
        En          = 1'b1;
        Start       = 1'b0;
        Num_Periods = 8'd1;
        repeat (3) @(negedge Clk);
        n_cmp++; if (Ratio_Crystal !== 32'd0) begin n_fail++; $display("FAIL reset_ratio: got %0d want 0", Ratio_Crystal); end
        n_cmp++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (Timeout_Err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", Timeout_Err); end
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_period4;
        logic [31:0] r;
        int nv;
        set_gen(4, 4, 1'b1);
        pulse_start(8'd1);
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL p4_busy_after_start: got %b want 1", Busy); end
        nv = 0;
        r  = 32'hxxxxxxxx;
        for (int i = 0; i < 150; i++) begin
            @(negedge Clk);
            if (Valid) begin
                if (nv == 0) r = Ratio_Crystal;
                nv++;
            end
        end
        n_cmp++; if (r !== 32'd400) begin n_fail++; $display("FAIL p4_ratio: got %0d want 400", r); end
        n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL p4_valid_count: got %0d want 1", nv); end
        n_cmp++; if (Timeout_Err !== 1'b0) begin n_fail++; $display("FAIL p4_tmo: got %b want 0", Timeout_Err); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL p4_busy_idle: got %b want 0", Busy); end
    endtask

    task automatic test_alternating;
        logic [31:0] r;
        int nv;
        set_gen(2, 3, 1'b1);
        run_measure(8'd2, 150, r, nv);
        n_cmp++; if (r !== 32'd250) begin n_fail++; $display("FAIL alt_ratio: got %0d want 250", r); end
        n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL alt_valid_count: got %0d want 1", nv); end
    endtask

    task automatic test_timeout;
        int  hit;
        int  nv;
        logic [31:0] r;
        set_gen(4, 4, 1'b0);
        pulse_start(8'd1);
        hit = 0;
        nv  = 0;
        for (int i = 1; i <= 101; i++) begin
            @(negedge Clk);
            if (Valid) nv++;
            if ((hit == 0) && Timeout_Err) hit = i;
        end
        n_cmp++; if (hit == 0) begin n_fail++; $display("FAIL tmo_set: got no Timeout_Err want set within 101 cycles"); end
        n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL tmo_no_valid: got %0d Valid pulses want 0", nv); end
        n_cmp++; if (Ratio_Crystal !== 32'd250) begin n_fail++; $display("FAIL tmo_ratio_hold: got %0d want 250", Ratio_Crystal); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", Busy); end
        set_gen(4, 4, 1'b1);
        n_cmp++; if (Timeout_Err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", Timeout_Err); end
        pulse_start(8'd1);
        n_cmp++; if (Timeout_Err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear_on_start: got %b want 0", Timeout_Err); end
        nv = 0;
        r  = 32'hxxxxxxxx;
        for (int i = 0; i < 150; i++) begin
            @(negedge Clk);
            if (Valid) begin
                if (nv == 0) r = Ratio_Crystal;
                nv++;
            end
        end
        n_cmp++; if (r !== 32'd400) begin n_fail++; $display("FAIL tmo_recover_ratio: got %0d want 400", r); end
    endtask

    task automatic test_period7;
        logic [31:0] r;
        int nv;
        set_gen(7, 7, 1'b1);
        run_measure(8'd0, 150, r, nv);
        n_cmp++; if (r !== 32'd700) begin n_fail++; $display("FAIL p7_k0_ratio: got %0d want 700", r); end
        n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL p7_k0_valid_count: got %0d want 1", nv); end
        run_measure(8'd3, 150, r, nv);
        n_cmp++; if (r !== 32'd700) begin n_fail++; $display("FAIL p7_k3_ratio: got %0d want 700", r); end
        n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL p7_k3_valid_count: got %0d want 1", nv); end
    endtask

    // A second Start while armed must not restart the timeout window.
    task automatic test_busy_start;
        int hit;
        set_gen(7, 7, 1'b0);
        pulse_start(8'd1);
        repeat (48) @(negedge Clk);
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_busy: got %b want 1", Busy); end
        pulse_start(8'd1);
        hit = 0;
        for (int i = 51; i <= 101; i++) begin
            @(negedge Clk);
            if ((hit == 0) && Timeout_Err) hit = i;
        end
        n_cmp++; if (hit == 0) begin n_fail++; $display("FAIL busy_start_ignored: got no Timeout_Err want set within 101 cycles of first Start"); end
        n_cmp++; if (Ratio_Crystal !== 32'd700) begin n_fail++; $display("FAIL busy_start_ratio: got %0d want 700", Ratio_Crystal); end
    endtask

    task automatic test_reset_divide;
        int nv;
        set_gen(4, 4, 1'b1);
        pulse_start(8'd1);
        repeat (24) @(negedge Clk);
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rstdiv_busy_before: got %b want 1", Busy); end
        #2;
        Reset_n = 1'b0;
        #1;
        n_cmp++; if (Ratio_Crystal !== 32'd0) begin n_fail++; $display("FAIL rstdiv_ratio: got %0d want 0", Ratio_Crystal); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rstdiv_busy: got %b want 0", Busy); end
        n_cmp++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL rstdiv_valid: got %b want 0", Valid); end
        n_cmp++; if (Timeout_Err !== 1'b0) begin n_fail++; $display("FAIL rstdiv_tmo: got %b want 0", Timeout_Err); end
        @(negedge Clk);
        Reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (Valid) nv++;
        end
        n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL rstdiv_no_valid: got %0d Valid pulses want 0", nv); end
        n_cmp++; if (Ratio_Crystal !== 32'd0) begin n_fail++; $display("FAIL rstdiv_ratio_after: got %0d want 0", Ratio_Crystal); end
    endtask

    task automatic test_pause;
        logic [31:0] r;
        int nv;
        int busy_low;
        set_gen(10, 10, 1'b1);
        run_measure(8'd2, 150, r, nv);
        n_cmp++; if (r !== 32'd1000) begin n_fail++; $display("FAIL pause_baseline: got %0d want 1000", r); end
        pulse_start(8'd2);
        repeat (17) @(negedge Clk);
        En        = 1'b0;
        gen_pause = 1'b1;
        nv        = 0;
        busy_low  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Valid) nv++;
            if (!Busy) busy_low++;
        end
        n_cmp++; if (nv !== 0) begin n_fail++; $display("FAIL pause_valid_low: got %0d Valid pulses want 0", nv); end
        n_cmp++; if (busy_low !== 0) begin n_fail++; $display("FAIL pause_busy_hold: got %0d low cycles want 0", busy_low); end
        En        = 1'b1;
        gen_pause = 1'b0;
        nv = 0;
        r  = 32'hxxxxxxxx;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Valid) begin
                if (nv == 0) r = Ratio_Crystal;
                nv++;
            end
        end
        n_cmp++; if (r !== 32'd1000) begin n_fail++; $display("FAIL pause_ratio: got %0d want 1000", r); end
        n_cmp++; if (nv !== 1) begin n_fail++; $display("FAIL pause_valid_count: got %0d want 1", nv); end
    endtask

    initial begin
        test_reset();
        test_period4();
        test_alternating();
        test_timeout();
        test_period7();
        test_busy_start();
        test_reset_divide();
        test_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
